// File: rtl/pipeline_stall_sequencer_if.sv
// Hazard/memory event inputs and per-stage pipeline controls exchanged with the stall sequencer.
interface pipeline_stall_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic             load_use_stall;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             clr_counters;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Write;
    logic             ID_EX_Flush;
    logic             EX_MEM_Write;
    logic             MEM_WB_Flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: raises events, consumes controls.
    modport master (
        output load_use_stall, ex_branch_taken, mem_req, mem_ready, clr_counters,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
        input  EX_MEM_Write, MEM_WB_Flush, halt, stall_cnt, flush_cnt
    );

    // Sequencer side.
    modport slave (
        input  load_use_stall, ex_branch_taken, mem_req, mem_ready, clr_counters,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
        output EX_MEM_Write, MEM_WB_Flush, halt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_stall_sequencer.sv
// Central stall/flush arbiter for the 5-stage pipeline: memory freeze > branch redirect > load-use,
// with a memory-wait timeout that halts the core and saturating stall/flush counters.
module pipeline_stall_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    pipeline_stall_sequencer_if.slave s_bus
);

    localparam int unsigned      WAIT_W     = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [WAIT_W-1:0] w_wait_inc;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_freeze;
    logic w_branch_apply;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_id_ex_write;
    logic w_id_ex_flush;
    logic w_ex_mem_write;
    logic w_mem_wb_flush;
    logic w_halt;

    assign w_freeze   = (r_state != ST_HALT) && s_bus.mem_req && !s_bus.mem_ready;
    // Count of consecutive ready-low cycles including the current one.
    assign w_wait_inc = (r_state == ST_MEM_WAIT) ? (r_wait_cnt + WAIT_W'(1)) : WAIT_W'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            ST_RUN, ST_MEM_WAIT: begin
                if (w_freeze) begin
                    w_wait_nxt = w_wait_inc;
                    if ((MEM_TIMEOUT != 0) && (w_wait_inc == WAIT_LIMIT)) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_state_nxt = ST_MEM_WAIT;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // Output decode; a MEM_WAIT cycle that is not frozen is the release cycle and decodes like RUN.
    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_write  = 1'b1;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_write = 1'b1;
        w_mem_wb_flush = 1'b0;
        w_halt         = 1'b0;
        w_branch_apply = 1'b0;
        if (rst) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_if_id_flush  = 1'b1;
            w_id_ex_write  = 1'b0;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_write = 1'b0;
            w_mem_wb_flush = 1'b1;
        end else if (r_state == ST_HALT) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_write  = 1'b0;
            w_ex_mem_write = 1'b0;
            w_halt         = 1'b1;
        end else if (w_freeze) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_write  = 1'b0;
            w_ex_mem_write = 1'b0;
            w_mem_wb_flush = 1'b1;
        end else if (s_bus.ex_branch_taken) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_branch_apply = 1'b1;
        end else if (s_bus.load_use_stall) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_flush  = 1'b1;
        end
    end

    // Saturating performance counters; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || s_bus.clr_counters) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((r_state != ST_HALT) && !w_pc_write && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_branch_apply && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign s_bus.PCWrite      = w_pc_write;
    assign s_bus.IF_ID_Write  = w_if_id_write;
    assign s_bus.IF_ID_Flush  = w_if_id_flush;
    assign s_bus.ID_EX_Write  = w_id_ex_write;
    assign s_bus.ID_EX_Flush  = w_id_ex_flush;
    assign s_bus.EX_MEM_Write = w_ex_mem_write;
    assign s_bus.MEM_WB_Flush = w_mem_wb_flush;
    assign s_bus.halt         = w_halt;
    assign s_bus.stall_cnt    = r_stall_cnt;
    assign s_bus.flush_cnt    = r_flush_cnt;

endmodule

// File: doc/pipeline_stall_sequencer.md
# pipeline_stall_sequencer

Central stall/flush controller for the 5-stage RV32I pipeline. It arbitrates between three stall/flush sources: the load-use stall request from hazard detection, a taken branch/jump resolved in EX, and a multi-cycle data-memory handshake from MEM. From these it produces one consistent set of per-stage write-enable and flush controls each cycle. It also tracks memory-wait time with a timeout that halts the core, and keeps saturating stall/flush performance counters.

## Interface
- MEM_TIMEOUT, default 16: maximum consecutive memory-wait cycles before halt; 0 disables the timeout.
- CNT_W, default 32: width of the performance counters.

- clk  input  1  pipeline clock.
- rst  input  1  reset, synchronous, active-high.
- load_use_stall  input  1  load-use hazard request from hazard detection.
- ex_branch_taken  input  1  taken branch/jump redirect in EX this cycle.
- mem_req  input  1  MEM stage holds a load/store needing data memory.
- mem_ready  input  1  data memory completes the access this cycle; ignored when mem_req=0.
- clr_counters  input  1  synchronous clear of both performance counters.
- PCWrite  output  1  PC register load enable.
- IF_ID_Write  output  1  IF/ID register enable.
- IF_ID_Flush  output  1  IF/ID register loads a NOP.
- ID_EX_Write  output  1  ID/EX register enable.
- ID_EX_Flush  output  1  ID/EX control bits cleared to a bubble.
- EX_MEM_Write  output  1  EX/MEM register enable.
- MEM_WB_Flush  output  1  MEM/WB register loads a bubble.
- halt  output  1  sticky memory-timeout error.
- stall_cnt  output  CNT_W  cycles with PCWrite=0, excluding reset and HALT.
- flush_cnt  output  CNT_W  cycles with a branch flush.

## Operation
- States: RUN, MEM_WAIT, HALT. Outputs are combinational from state and inputs. State and counters are registered.
- **Default (no event)**
  - All Write outputs are 1; all Flush outputs are 0.
- **Priority 1: memory freeze**
  - Active when (RUN or MEM_WAIT) and mem_req=1 and mem_ready=0.
  - PCWrite, IF_ID_Write, ID_EX_Write and EX_MEM_Write are 0; MEM_WB_Flush is 1.
  - IF_ID_Flush and ID_EX_Flush are 0, so a branch in EX is held and re-evaluated later.
  - load_use_stall and ex_branch_taken are ignored.
- **Priority 2: branch redirect** (ex_branch_taken=1)
  - PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1.
  - load_use_stall is ignored because the ID instruction is discarded.
- **Priority 3: load-use** (load_use_stall=1)
  - PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
- **Transitions**
  - RUN→MEM_WAIT on memory freeze; wait_cnt←1.
  - MEM_WAIT stays while mem_ready=0; wait_cnt increments.
  - MEM_WAIT→HALT when mem_ready=0 and wait_cnt==MEM_TIMEOUT (only when MEM_TIMEOUT≠0).
  - MEM_WAIT→RUN in the cycle mem_ready=1. That release cycle is decoded as in RUN: the pipeline advances, and branch/load-use are applied.
  - mem_req dropping to 0 in MEM_WAIT is also treated as release.
  - HALT is left only via rst.
- **HALT**
  - All Write outputs 0, all Flush outputs 0, halt=1.
  - Counters hold.
- **wait_cnt** is internal and sized $clog2(MEM_TIMEOUT+1), minimum 1 bit.
- **Counters**
  - stall_cnt +1 on every non-reset, non-HALT cycle with PCWrite=0.
  - flush_cnt +1 on every cycle in which priority 2 is applied.
  - Both saturate at 2^CNT_W−1.
  - clr_counters clears both and wins over a same-cycle increment.

## Timing
- **Reset**
  - rst is sampled on the rising edge of clk.
  - While rst=1, outputs are forced: PCWrite=IF_ID_Write=ID_EX_Write=EX_MEM_Write=0, IF_ID_Flush=ID_EX_Flush=MEM_WB_Flush=1, halt=0.
  - After the reset edge: state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0.
- **Reset mid-wait or in HALT**: returns to RUN on the next edge; no residual wait count.
- **Latency**: zero cycles. Controls respond in the same cycle as their inputs.
- **Memory freeze duration**: a miss with mem_ready low for N cycles freezes the pipeline exactly N cycles.
  - mem_req and mem_ready both high in the same RUN cycle gives no stall.
- **Load-use**: each cycle of load_use_stall costs exactly one stall cycle. The hazard source deasserts once the bubble reaches EX.
- **Timeout**: with MEM_TIMEOUT=T, halt rises at the edge ending the T-th consecutive ready-low cycle and is visible from cycle T+1.

## Test plan
- **Reset**: rst for 2 cycles → forced output values during reset. After release with no events: all Write=1, all Flush=0, halt=0, both counters 0.
- **Load-use**: load_use_stall=1 for one cycle → PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 that cycle only; stall_cnt=1.
- **Branch over load-use**: ex_branch_taken=1 and load_use_stall=1 together → PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1; flush_cnt=1, stall_cnt unchanged.
- **Memory wait with held branch**: mem_req=1, mem_ready=0 for 3 cycles, ex_branch_taken=1 throughout, then mem_ready=1 → 3 frozen cycles with MEM_WB_Flush=1 and no front-end flush. On the release cycle: PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1. Final stall_cnt=3, flush_cnt=1.
- **Timeout**: MEM_TIMEOUT=4, mem_req=1, mem_ready never rises → halt=1 from cycle 5 with all Write=0. Raising mem_ready has no effect; rst returns to RUN with halt=0.
- **Counter saturation and clear**: CNT_W=2, 5 load-use cycles → stall_cnt saturates at 3. clr_counters asserted during a further stall cycle → stall_cnt=0.
